// File: rtl/rv32_pkg.sv
// Shared RV32I datapath constants, ALU op codes and the ID/EX register payload.
package rv32_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic            rs1_used;
    logic            rs2_used;
    logic [3:0]      alu_op;
    logic            a_pc;
    logic            b_imm;
    logic            rd_we;
    logic            mem_rd;
    logic            mem_wr;
  } id_ex_t;

endpackage

// File: rtl/fwd_unit.sv
// Per-operand forwarding mux: EX/MEM (non-load) beats MEM/WB beats the register value.
module fwd_unit
  import rv32_pkg::*;
(
  input  logic [RW-1:0]   rs_addr_i,
  input  logic [XLEN-1:0] rs_data_i,
  input  logic [RW-1:0]   exm_rd_i,
  input  logic            exm_we_i,
  input  logic            exm_load_i,
  input  logic [XLEN-1:0] exm_result_i,
  input  logic [RW-1:0]   mwb_rd_i,
  input  logic            mwb_we_i,
  input  logic [XLEN-1:0] mwb_result_i,
  output logic [XLEN-1:0] fwd_data_o
);

  logic nz;
  assign nz = (rs_addr_i != '0);

  always_comb begin
    fwd_data_o = rs_data_i;
    // A load in EX/MEM has no data yet; the load-use interlock covers that case.
    if (nz && exm_we_i && !exm_load_i && (exm_rd_i == rs_addr_i)) begin
      fwd_data_o = exm_result_i;
    end else if (nz && mwb_we_i && (mwb_rd_i == rs_addr_i)) begin
      fwd_data_o = mwb_result_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: forwarding, ALU operand select, handshake, load-use interlock, flush.
module id_ex_stage
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RW-1:0]   in_rs1,
  input  logic [RW-1:0]   in_rs2,
  input  logic [RW-1:0]   in_rd,
  input  logic            in_rs1_used,
  input  logic            in_rs2_used,
  input  logic [3:0]      in_alu_op,
  input  logic            in_a_pc,
  input  logic            in_b_imm,
  input  logic            in_rd_we,
  input  logic            in_mem_rd,
  input  logic            in_mem_wr,
  input  logic [RW-1:0]   exm_rd,
  input  logic            exm_we,
  input  logic            exm_load,
  input  logic [XLEN-1:0] exm_result,
  input  logic [RW-1:0]   mwb_rd,
  input  logic            mwb_we,
  input  logic [XLEN-1:0] mwb_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] out_pc,
  output logic [RW-1:0]   out_rd,
  output logic            out_rd_we,
  output logic            out_mem_rd,
  output logic            out_mem_wr
);

  logic            valid_q, valid_d;
  id_ex_t          ie_q, ie_d;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;
  logic            lu, ov, transfer, accept;

  fwd_unit u_fwd_rs1 (
    .rs_addr_i    (ie_q.rs1),
    .rs_data_i    (ie_q.rs1_data),
    .exm_rd_i     (exm_rd),
    .exm_we_i     (exm_we),
    .exm_load_i   (exm_load),
    .exm_result_i (exm_result),
    .mwb_rd_i     (mwb_rd),
    .mwb_we_i     (mwb_we),
    .mwb_result_i (mwb_result),
    .fwd_data_o   (fwd_rs1)
  );

  fwd_unit u_fwd_rs2 (
    .rs_addr_i    (ie_q.rs2),
    .rs_data_i    (ie_q.rs2_data),
    .exm_rd_i     (exm_rd),
    .exm_we_i     (exm_we),
    .exm_load_i   (exm_load),
    .exm_result_i (exm_result),
    .mwb_rd_i     (mwb_rd),
    .mwb_we_i     (mwb_we),
    .mwb_result_i (mwb_result),
    .fwd_data_o   (fwd_rs2)
  );

  assign lu = valid_q && exm_load && exm_we && (exm_rd != '0) &&
              ((ie_q.rs1_used && (exm_rd == ie_q.rs1)) ||
               (ie_q.rs2_used && (exm_rd == ie_q.rs2)));

  assign ov       = !rst && valid_q && !lu && !flush;
  assign transfer = ov && out_ready;
  assign in_ready = !rst && !flush && (!valid_q || transfer);
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    ie_d    = ie_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d       = 1'b1;
      ie_d.pc       = in_pc;
      ie_d.rs1_data = in_rs1_data;
      ie_d.rs2_data = in_rs2_data;
      ie_d.imm      = in_imm;
      ie_d.rs1      = in_rs1;
      ie_d.rs2      = in_rs2;
      ie_d.rd       = in_rd;
      ie_d.rs1_used = in_rs1_used;
      ie_d.rs2_used = in_rs2_used;
      ie_d.alu_op   = in_alu_op;
      ie_d.a_pc     = in_a_pc;
      ie_d.b_imm    = in_b_imm;
      ie_d.rd_we    = in_rd_we;
      ie_d.mem_rd   = in_mem_rd;
      ie_d.mem_wr   = in_mem_wr;
    end else if (transfer) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // Capture producers that retire while we wait so their values are not lost.
      ie_d.rs1_data = fwd_rs1;
      ie_d.rs2_data = fwd_rs2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ie_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ie_q    <= ie_d;
    end
  end

  always_comb begin
    out_valid  = ov;
    alu_a      = '0;
    alu_b      = '0;
    alu_op     = '0;
    store_data = '0;
    out_pc     = '0;
    out_rd     = '0;
    out_rd_we  = 1'b0;
    out_mem_rd = 1'b0;
    out_mem_wr = 1'b0;
    if (!rst) begin
      alu_a      = ie_q.a_pc ? ie_q.pc : fwd_rs1;
      alu_b      = ie_q.b_imm ? ie_q.imm : fwd_rs2;
      alu_op     = ie_q.alu_op;
      store_data = fwd_rs2;
      out_pc     = ie_q.pc;
      out_rd     = ie_q.rd;
      out_rd_we  = ie_q.rd_we;
      out_mem_rd = ie_q.mem_rd;
      out_mem_wr = ie_q.mem_wr;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized scoreboard bench for id_ex_stage against a behavioural operand/handshake model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rs1_used, in_rs2_used;
  logic [3:0]  in_alu_op;
  logic        in_a_pc, in_b_imm, in_rd_we, in_mem_rd, in_mem_wr;
  logic [4:0]  exm_rd, mwb_rd;
  logic        exm_we, exm_load, mwb_we;
  logic [31:0] exm_result, mwb_result;
  logic        out_valid, out_ready;
  logic [31:0] alu_a, alu_b, store_data, out_pc;
  logic [3:0]  alu_op;
  logic [4:0]  out_rd;
  logic        out_rd_we, out_mem_rd, out_mem_wr;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used), .in_alu_op(in_alu_op),
    .in_a_pc(in_a_pc), .in_b_imm(in_b_imm), .in_rd_we(in_rd_we),
    .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
    .exm_rd(exm_rd), .exm_we(exm_we), .exm_load(exm_load), .exm_result(exm_result),
    .mwb_rd(mwb_rd), .mwb_we(mwb_we), .mwb_result(mwb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .store_data(store_data),
    .out_pc(out_pc), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr)
  );

  typedef struct packed {
    logic [31:0] a, b, st, pc;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        we, mrd, mwr;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Model of the held instruction: its fields plus the newest known operand values.
  logic        m_valid;
  logic [31:0] m_pc, m_v1, m_v2, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic        m_u1, m_u2, m_apc, m_bimm, m_we, m_mrd, m_mwr;
  logic [3:0]  m_op;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Newest architectural value of register r given the producers now in flight.
  function automatic logic [31:0] newest(input logic [4:0] r, input logic [31:0] v);
    if (r == 5'd0) return v;
    if (exm_we && !exm_load && exm_rd == r) return exm_result;
    if (mwb_we && mwb_rd == r) return mwb_result;
    return v;
  endfunction

  // Monitor: pops an expectation whenever the DUT hands an instruction to the ALU.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_transfer", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("alu_a", alu_a, e.a);
          check("alu_b", alu_b, e.b);
          check("store_data", store_data, e.st);
          check("alu_op", {28'd0, alu_op}, {28'd0, e.op});
          check("out_pc", out_pc, e.pc);
          check("out_ctrl", {24'd0, out_rd, out_rd_we, out_mem_rd, out_mem_wr},
                {24'd0, e.rd, e.we, e.mrd, e.mwr});
        end
      end
    end
  end

  initial begin
    logic lu, ov, ir, xfer;
    logic [31:0] f1, f2;
    m_valid = 1'b0;
    {m_pc, m_v1, m_v2, m_imm, m_rs1, m_rs2, m_rd} = '0;
    {m_u1, m_u2, m_apc, m_bimm, m_we, m_mrd, m_mwr, m_op} = '0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst         = (cyc < 3) || ($urandom_range(0, 199) == 0);
      flush       = ($urandom_range(0, 19) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      in_pc       = $urandom;
      in_rs1_data = $urandom;
      in_rs2_data = $urandom;
      in_imm      = $urandom;
      in_rs1      = 5'($urandom_range(0, 3));
      in_rs2      = 5'($urandom_range(0, 3));
      in_rd       = 5'($urandom_range(0, 31));
      in_rs1_used = $urandom_range(0, 1) == 1;
      in_rs2_used = $urandom_range(0, 1) == 1;
      in_alu_op   = 4'($urandom_range(0, 9));
      in_a_pc     = ($urandom_range(0, 3) == 0);
      in_b_imm    = ($urandom_range(0, 2) == 0);
      in_rd_we    = $urandom_range(0, 1) == 1;
      in_mem_rd   = $urandom_range(0, 1) == 1;
      in_mem_wr   = $urandom_range(0, 1) == 1;
      exm_rd      = 5'($urandom_range(0, 3));
      exm_we      = ($urandom_range(0, 2) != 0);
      exm_load    = ($urandom_range(0, 3) == 0);
      exm_result  = $urandom;
      mwb_rd      = 5'($urandom_range(0, 3));
      mwb_we      = ($urandom_range(0, 2) != 0);
      mwb_result  = $urandom;
      #1;
      f1   = newest(m_rs1, m_v1);
      f2   = newest(m_rs2, m_v2);
      lu   = m_valid && exm_load && exm_we && exm_rd != 5'd0 &&
             ((m_u1 && exm_rd == m_rs1) || (m_u2 && exm_rd == m_rs2));
      ov   = !rst && m_valid && !lu && !flush;
      ir   = !rst && !flush && (!m_valid || (ov && out_ready));
      xfer = ov && out_ready;
      check("out_valid", {31'd0, out_valid}, {31'd0, ov});
      check("in_ready", {31'd0, in_ready}, {31'd0, ir});
      if (rst) begin
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_store", store_data, 32'd0);
        check("rst_misc", {out_pc[31:10] | out_pc[9:0], alu_op, out_rd,
              out_rd_we, out_mem_rd, out_mem_wr}, 32'd0);
      end
      if (xfer) begin
        sb_q.push_back('{a: m_apc ? m_pc : f1, b: m_bimm ? m_imm : f2, st: f2, pc: m_pc,
                         op: m_op, rd: m_rd, we: m_we, mrd: m_mrd, mwr: m_mwr});
      end
      if (rst) begin
        m_valid = 1'b0;
        {m_pc, m_v1, m_v2, m_imm, m_rs1, m_rs2, m_rd} = '0;
        {m_u1, m_u2, m_apc, m_bimm, m_we, m_mrd, m_mwr, m_op} = '0;
      end else if (flush) begin
        m_valid = 1'b0;
      end else if (in_valid && ir) begin
        m_valid = 1'b1;
        m_pc = in_pc; m_v1 = in_rs1_data; m_v2 = in_rs2_data; m_imm = in_imm;
        m_rs1 = in_rs1; m_rs2 = in_rs2; m_rd = in_rd; m_u1 = in_rs1_used;
        m_u2 = in_rs2_used; m_op = in_alu_op; m_apc = in_a_pc; m_bimm = in_b_imm;
        m_we = in_rd_we; m_mrd = in_mem_rd; m_mwr = in_mem_wr;
      end else if (xfer) begin
        m_valid = 1'b0;
      end else if (m_valid) begin
        m_v1 = f1;
        m_v2 = f2;
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #4;
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Single-entry ID/EX pipeline register of the RV32I core, sitting directly upstream of the ALU. It captures a decoded instruction, resolves operand forwarding from EX/MEM and MEM/WB, selects the ALU operands (register, PC or immediate), and drives `a`, `b` and `op` into the ALU. It also provides a valid/ready handshake, a load-use interlock and a flush path.

## Interface
- `XLEN`, 32, datapath width.
- `RW`, 5, register-address width.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `flush  in  1`: kill held instruction (branch/jump redirect).
- `in_valid  in  1` / `in_ready  out  1`: decode-side handshake.
- `in_pc, in_rs1_data, in_rs2_data, in_imm  in  XLEN`: decoded fields.
- `in_rs1, in_rs2, in_rd  in  RW`: register addresses.
- `in_rs1_used, in_rs2_used  in  1`: operand actually read.
- `in_alu_op  in  4`: ALU op code.
- `in_a_pc, in_b_imm  in  1`: operand selects.
- `in_rd_we, in_mem_rd, in_mem_wr  in  1`: control.
- `exm_rd  in  RW`, `exm_we  in  1`, `exm_load  in  1`, `exm_result  in  XLEN`: EX/MEM producer.
- `mwb_rd  in  RW`, `mwb_we  in  1`, `mwb_result  in  XLEN`: MEM/WB producer.
- `out_valid  out  1` / `out_ready  in  1`: ALU/EX-side handshake.
- `alu_a, alu_b  out  XLEN`: ALU operands.
- `alu_op  out  4`: ALU op code.
- `store_data  out  XLEN`: forwarded rs2.
- `out_pc  out  XLEN`, `out_rd  out  RW`, `out_rd_we, out_mem_rd, out_mem_wr  out  1`.

## Operation
- State: `valid_q` plus registered copies of every `in_*` field. `rs1_q`/`rs2_q` hold operand values.
- Forwarding, per source s ∈ {rs1, rs2}: if `exm_we && exm_rd==s_q && s_q!=0 && !exm_load`, use `exm_result`; else if `mwb_we && mwb_rd==s_q && s_q!=0`, use `mwb_result`; else use the register value. EX/MEM has priority. x0 is never forwarded.
- `alu_a` = `a_pc_q ? pc_q : fwd_rs1`.
- `alu_b` = `b_imm_q ? imm_q : fwd_rs2`.
- `store_data` = `fwd_rs2`.
- `alu_op` is the registered `in_alu_op`, with codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
- Load-use hazard (`lu`): `valid_q && exm_load && exm_we && exm_rd!=0` and (`rs1_used_q && exm_rd==rs1_q` or `rs2_used_q && exm_rd==rs2_q`).
- `out_valid = valid_q && !lu && !flush`.
- `in_ready = !rst && !flush && (!valid_q || (out_valid && out_ready))`.
- Accept: `in_valid && in_ready` loads all fields and sets `valid_q`=1.
- Drain without accept: `valid_q`=0.
- Hold refresh: while `valid_q` is set and no transfer occurs, `rs1_q`/`rs2_q` are overwritten with their forwarded values every cycle. A producer that retires during a stall is therefore not lost.
- Flush: `valid_q`=0 next cycle and the input is not accepted. Flush outranks accept and hold.
- Reset: `valid_q` and all registers clear to 0. During reset `out_valid`=0, `in_ready`=0, and `alu_a`, `alu_b`, `alu_op`, `store_data` and `out_*` are all 0.

## Timing
- Latency: 1 cycle from accept to `out_valid`. ALU outputs are combinational from registered state plus the forwarding inputs.
- Throughput: 1 instruction/cycle when `out_ready`=1 and no hazard. Pass-through (drain and accept) happens in the same cycle.
- Load-use: exactly 1 bubble cycle (`out_valid`=0, `in_ready`=0). The next cycle the value arrives via `mwb_result` and `out_valid` rises.
- Once asserted, `out_valid` stays high and the outputs stay stable until transfer or flush. The exception is the forwarded-value update, which only replaces stale data with newer data for the same register.
- Reset or flush mid-stall: the instruction is dropped and the stage is empty the next cycle.

## Structure
- Shared package `rv32_pkg`: `XLEN`, `RW`, and the ALU op-code constants `ALU_ADD`..`ALU_SLTU`. The ALU and decode import the same constants.
- One sub-module, `fwd_unit`: a combinational per-operand priority mux. It takes the register address and value plus both producers, and returns the forwarded value. It is instantiated twice.

## Test plan
- Basic pass-through: accept ADD with rs1=5, rs2=5, no forwarding → next cycle `out_valid`=1, `alu_a`=5, `alu_b`=5, `alu_op`=0.
- Forward priority: rs1=x3, with `exm_rd`=3 (result 66) and `mwb_rd`=3 (result 11) → `alu_a`=66. With rd=0 on both producers → the register value is used.
- Load-use: `exm_load`=1, `exm_rd`=7, held instruction reads x7 → exactly 1 bubble, then `alu_a`=`mwb_result` (e.g. -8 for SRA, b=2).
- Stall refresh: `out_ready`=0 for 3 cycles while `mwb_result`=9 for rs2 retires in cycle 1 → after release, `alu_b`=9.
- Immediate/PC select: `in_b_imm`=1, imm=-1, SLTU with rs1=9 → `alu_b`=0xFFFFFFFF. `in_a_pc`=1 → `alu_a`=`in_pc`.
- Flush/reset: flush with `in_valid`=1 and a held instruction → `out_valid`=0 and nothing accepted. Asserting `rst` mid-stall → all outputs 0 the next cycle.
